// File: rtl/top_traffic_controller.sv
// Fixed-time two-way intersection controller: a prescaler tick drives a per-phase
// timer, which steps a six-state Moore FSM decoded straight to the lamp outputs.
//
//  state        | meaning
//  -------------+-------------------------------------------
//  RED_TO_NS    | all-red clearance before North-South green
//  NS_GREEN     | North-South green, East-West red
//  NS_YELLOW    | North-South yellow, East-West red
//  RED_TO_EW    | all-red clearance before East-West green
//  EW_GREEN     | East-West green, North-South red
//  EW_YELLOW    | East-West yellow, North-South red
module top_traffic_controller #(
   parameter int TICK_DIV      = 100,
   parameter int GREEN_TICKS   = 200,
   parameter int YELLOW_TICKS  = 50,
   parameter int ALL_RED_TICKS = 10
) (
   input  logic clk,
   input  logic reset_n,
   output logic NS_R,
   output logic NS_Y,
   output logic NS_G,
   output logic EW_R,
   output logic EW_Y,
   output logic EW_G
);

   localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int MAX_A = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
   localparam int MAX_T = (MAX_A > ALL_RED_TICKS) ? MAX_A : ALL_RED_TICKS;
   localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

   localparam logic [PW-1:0] PRESC_LAST   = PW'(TICK_DIV - 1);
   localparam logic [TW-1:0] GREEN_LAST   = TW'(GREEN_TICKS - 1);
   localparam logic [TW-1:0] YELLOW_LAST  = TW'(YELLOW_TICKS - 1);
   localparam logic [TW-1:0] ALL_RED_LAST = TW'(ALL_RED_TICKS - 1);

   localparam logic [2:0] S_RED_TO_NS = 3'd0;
   localparam logic [2:0] S_NS_GREEN  = 3'd1;
   localparam logic [2:0] S_NS_YELLOW = 3'd2;
   localparam logic [2:0] S_RED_TO_EW = 3'd3;
   localparam logic [2:0] S_EW_GREEN  = 3'd4;
   localparam logic [2:0] S_EW_YELLOW = 3'd5;

   logic [PW-1:0] presc_q, presc_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    state_q, state_d;
   logic          tick;
   logic [TW-1:0] dur_last;
   logic [2:0]    state_nxt;
   logic          state_ok;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         timer_q <= '0;
         state_q <= S_RED_TO_NS;
      end else begin
         presc_q <= presc_d;
         timer_q <= timer_d;
         state_q <= state_d;
      end
   end

   always_comb begin
      tick    = (presc_q == PRESC_LAST);
      presc_d = tick ? '0 : presc_q + PW'(1);
   end

   always_comb begin
      dur_last  = ALL_RED_LAST;
      state_nxt = S_RED_TO_NS;
      state_ok  = 1'b1;
      case (state_q)
         S_RED_TO_NS: begin dur_last = ALL_RED_LAST; state_nxt = S_NS_GREEN;  end
         S_NS_GREEN:  begin dur_last = GREEN_LAST;   state_nxt = S_NS_YELLOW; end
         S_NS_YELLOW: begin dur_last = YELLOW_LAST;  state_nxt = S_RED_TO_EW; end
         S_RED_TO_EW: begin dur_last = ALL_RED_LAST; state_nxt = S_EW_GREEN;  end
         S_EW_GREEN:  begin dur_last = GREEN_LAST;   state_nxt = S_EW_YELLOW; end
         S_EW_YELLOW: begin dur_last = YELLOW_LAST;  state_nxt = S_RED_TO_NS; end
         default:     state_ok = 1'b0;
      endcase
   end

   // Unused encodings recover to the start of the cycle without waiting for a tick.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      if (!state_ok) begin
         state_d = S_RED_TO_NS;
         timer_d = '0;
      end else if (tick) begin
         if (timer_q == dur_last) begin
            state_d = state_nxt;
            timer_d = '0;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end
   end

   always_comb begin
      NS_R = 1'b1;
      NS_Y = 1'b0;
      NS_G = 1'b0;
      EW_R = 1'b1;
      EW_Y = 1'b0;
      EW_G = 1'b0;
      case (state_q)
         S_NS_GREEN:  begin NS_R = 1'b0; NS_G = 1'b1; end
         S_NS_YELLOW: begin NS_R = 1'b0; NS_Y = 1'b1; end
         S_EW_GREEN:  begin EW_R = 1'b0; EW_G = 1'b1; end
         S_EW_YELLOW: begin EW_R = 1'b0; EW_Y = 1'b1; end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_top_traffic_controller.sv
// Scoreboard bench: expected lamp transitions (cycle, lamps) are queued up front and a
// negedge monitor pops one each time a controller's lamp pattern changes.
module tb_top_traffic_controller;

   typedef struct packed {
      int         cyc;
      logic [5:0] lamps;
   } exp_t;

   // {NS_R,NS_Y,NS_G,EW_R,EW_Y,EW_G}
   localparam logic [5:0] L_AR  = 6'b100_100;
   localparam logic [5:0] L_NSG = 6'b001_100;
   localparam logic [5:0] L_NSY = 6'b010_100;
   localparam logic [5:0] L_EWG = 6'b100_001;
   localparam logic [5:0] L_EWY = 6'b100_010;

   logic clk;
   logic reset_n_a, reset_n_b, reset_n_c;
   logic [5:0] lamps_a, lamps_b, lamps_c;
   int cyc_a, cyc_b, cyc_c;
   int n_vec, n_err;
   bit done;
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];
   logic [5:0] prev_l [3];

   top_traffic_controller u_dut_a (
      .clk(clk), .reset_n(reset_n_a),
      .NS_R(lamps_a[5]), .NS_Y(lamps_a[4]), .NS_G(lamps_a[3]),
      .EW_R(lamps_a[2]), .EW_Y(lamps_a[1]), .EW_G(lamps_a[0]));

   top_traffic_controller u_dut_b (
      .clk(clk), .reset_n(reset_n_b),
      .NS_R(lamps_b[5]), .NS_Y(lamps_b[4]), .NS_G(lamps_b[3]),
      .EW_R(lamps_b[2]), .EW_Y(lamps_b[1]), .EW_G(lamps_b[0]));

   top_traffic_controller #(
      .TICK_DIV(1), .GREEN_TICKS(3), .YELLOW_TICKS(2), .ALL_RED_TICKS(1)
   ) u_dut_c (
      .clk(clk), .reset_n(reset_n_c),
      .NS_R(lamps_c[5]), .NS_Y(lamps_c[4]), .NS_G(lamps_c[3]),
      .EW_R(lamps_c[2]), .EW_Y(lamps_c[1]), .EW_G(lamps_c[0]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cycle N = Nth rising edge after the reset release
   always @(posedge clk) begin
      cyc_a <= reset_n_a ? cyc_a + 1 : 0;
      cyc_b <= reset_n_b ? cyc_b + 1 : 0;
      cyc_c <= reset_n_c ? cyc_c + 1 : 0;
   end

   task automatic push(input int id, input int cyc, input logic [5:0] lamps);
      exp_t e;
      e.cyc   = cyc;
      e.lamps = lamps;
      case (id)
         0:       q_a.push_back(e);
         1:       q_b.push_back(e);
         default: q_c.push_back(e);
      endcase
   endtask

   task automatic chk(input int id, input logic rst, input logic [5:0] lamps,
                      input int cyc, input bit en);
      exp_t e;
      bit   got;
      n_vec++;
      if (!$onehot(lamps[5:3]) || !$onehot(lamps[2:0]) || !(lamps[5] | lamps[2])) begin
         n_err++;
         $display("FAIL invariant dut%0d: cycle %0d lamps %b, required one lamp per direction and one red",
                  id, cyc, lamps);
      end
      if (!rst) begin
         n_vec++;
         if (lamps != L_AR) begin
            n_err++;
            $display("FAIL reset_allred dut%0d: lamps %b, required %b", id, lamps, L_AR);
         end
         prev_l[id] = L_AR;
      end else begin
         if (en && lamps != prev_l[id]) begin
            got = 1'b0;
            case (id)
               0: if (q_a.size() > 0) begin e = q_a.pop_front(); got = 1'b1; end
               1: if (q_b.size() > 0) begin e = q_b.pop_front(); got = 1'b1; end
               default: if (q_c.size() > 0) begin e = q_c.pop_front(); got = 1'b1; end
            endcase
            n_vec++;
            if (!got) begin
               n_err++;
               $display("FAIL unexpected_change dut%0d: cycle %0d lamps %b, required no change",
                        id, cyc, lamps);
            end else if (e.cyc != cyc || e.lamps != lamps) begin
               n_err++;
               $display("FAIL transition dut%0d: cycle %0d lamps %b, required cycle %0d lamps %b",
                        id, cyc, lamps, e.cyc, e.lamps);
            end
         end
         prev_l[id] = lamps;
      end
   endtask

   always @(negedge clk) begin
      if (!done) begin
         chk(0, reset_n_a, lamps_a, cyc_a, 1'b1);
         chk(1, reset_n_b, lamps_b, cyc_b, 1'b1);
         chk(2, reset_n_c, lamps_c, cyc_c, cyc_c <= 60);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      done  = 1'b0;
      reset_n_a = 1'b0;
      reset_n_b = 1'b0;
      reset_n_c = 1'b0;
      for (int i = 0; i < 3; i++) prev_l[i] = L_AR;

      push(0, 1000, L_NSG);
      push(0, 21000, L_NSY);
      push(0, 26000, L_AR);
      push(0, 27000, L_EWG);
      push(0, 47000, L_EWY);
      push(0, 52000, L_AR);
      push(0, 53000, L_NSG);

      push(1, 1000, L_NSG);
      push(1, 21000, L_NSY);
      push(1, 26000, L_AR);
      push(1, 27000, L_EWG);

      for (int k = 0; k < 5; k++) begin
         push(2, 12 * k + 1,  L_NSG);
         push(2, 12 * k + 4,  L_NSY);
         push(2, 12 * k + 6,  L_AR);
         push(2, 12 * k + 7,  L_EWG);
         push(2, 12 * k + 10, L_EWY);
         push(2, 12 * k + 12, L_AR);
      end

      #102;
      reset_n_a = 1'b1;
      reset_n_b = 1'b1;
      reset_n_c = 1'b1;

      // short reset pulse on the second controller while it is in EW green
      wait (cyc_b == 30000);
      @(negedge clk);
      #2 reset_n_b = 1'b0;
      #1;
      n_vec++;
      if (lamps_b != L_AR) begin
         n_err++;
         $display("FAIL async_reset: lamps %b, required %b", lamps_b, L_AR);
      end
      n_vec++;
      if (q_b.size() != 0) begin
         n_err++;
         $display("FAIL pre_reset_events: %0d left, required 0", q_b.size());
      end
      push(1, 1000, L_NSG);
      push(1, 21000, L_NSY);
      #29 reset_n_b = 1'b1;

      wait (cyc_a == 53005);
      @(negedge clk);
      #1 done = 1'b1;

      n_vec++;
      if (q_a.size() != 0) begin
         n_err++;
         $display("FAIL missing_a: %0d transitions not seen, required 0", q_a.size());
      end
      n_vec++;
      if (q_b.size() != 0) begin
         n_err++;
         $display("FAIL missing_b: %0d transitions not seen, required 0", q_b.size());
      end
      n_vec++;
      if (q_c.size() != 0) begin
         n_err++;
         $display("FAIL missing_c: %0d transitions not seen, required 0", q_c.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
